mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 3, giving the number of requesters (0 = feature fetch, 1 = weight fetch, 2 = output writeback).
REQ-002 SHALL have parameter EXT_MEM_HEIGHT, default 1<<20, giving memory depth; ADDR_W = $clog2(EXT_MEM_HEIGHT).
REQ-003 SHALL have parameter EXT_MEM_WIDTH, default 32, giving the data word width.
REQ-004 SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port arst_n_in, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, NB_REQ bits: per-requester command valid.
REQ-008 SHALL have port req_ready, output, NB_REQ bits: per-requester command accepted.
REQ-009 SHALL have port req_we, input, NB_REQ bits: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, NB_REQ x ADDR_W: command address.
REQ-011 SHALL have port req_wdata, input, NB_REQ x EXT_MEM_WIDTH: write data.
REQ-012 SHALL have port rsp_valid, output, NB_REQ bits: read-data valid, one-hot.
REQ-013 SHALL have port rsp_data, output, EXT_MEM_WIDTH: read data, shared by all requesters.
REQ-014 SHALL have ports mem_en, mem_we (outputs, 1 bit), mem_addr (output, ADDR_W), mem_wdata (output, EXT_MEM_WIDTH) and mem_rdata (input, EXT_MEM_WIDTH), forming the external memory port.
REQ-015 SHALL have port grant_id, output, $clog2(NB_REQ) bits: current owner; port busy, output, 1 bit: the FSM is in GRANT.

Function
REQ-016 SHALL implement states IDLE and GRANT.
REQ-017 In IDLE with any req_valid high, SHALL latch as owner the first valid requester at or after rr_ptr (cyclic), then enter GRANT next cycle; IDLE asserts no req_ready.
REQ-018 In GRANT, req_ready SHALL be high only for the owner, combinationally; all other bits stay 0.
REQ-019 A beat SHALL occur when req_valid[owner] & req_ready[owner]; in that same cycle mem_en=1 and mem_we/mem_addr/mem_wdata SHALL equal the owner's inputs (combinational pass-through).
REQ-020 With no beat, mem_en SHALL be 0; mem_we, mem_addr and mem_wdata are don't-care.
REQ-021 Memory read latency is fixed at 1 cycle: a read beat at cycle t SHALL give rsp_valid[owner_t]=1 and rsp_data=mem_rdata at cycle t+1, with the requester id registered.
REQ-022 Beat counter SHALL count beats within a grant; on the beat making count == MAX_BURST, or in any GRANT cycle with req_valid[owner]=0, the arbiter SHALL return to IDLE next cycle.
REQ-023 On release, rr_ptr SHALL become (owner+1) mod NB_REQ, and the released requester has lowest priority at the next arbitration.
REQ-024 Each grant SHALL cost one arbitration bubble cycle (IDLE); sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles.
REQ-025 Inputs of non-owners SHALL be ignored; a requester that deasserts valid while not owner loses nothing.
REQ-026 A read response from the final beat of a grant SHALL still be delivered in the following (IDLE) cycle.
REQ-027 No starvation: a continuously valid requester SHALL be granted within NB_REQ-1 intervening grants.

Reset
REQ-028 On arst_n_in low, SHALL immediately set state=IDLE, rr_ptr=0, beat count=0, grant_id=0, busy=0, req_ready=0, rsp_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_data=0.
REQ-029 Reset mid-grant SHALL drop the in-flight read response (no rsp_valid after release); operation resumes on the first clk edge after deassertion.

Structure
REQ-030 Requester ids (REQ_FEAT=0, REQ_WGT=1, REQ_OUT=2), the state enum and the MAX_BURST default SHALL live in a shared package mem_arb_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector and pointer; output: index and found flag), purely combinational.

Verification
REQ-032 Bench SHALL check: after reset, only req 1 is valid, 3 reads at addr 0x10..0x12 -> grant_id=1; beats on cycles 2-4; rsp_valid[1] on cycles 3-5 with matching mem_rdata.
REQ-033 Bench SHALL check: all 3 requesters valid continuously, MAX_BURST=4 -> grant order 0,1,2,0 with 4 beats each and 1 bubble between grants.
REQ-034 Bench SHALL check: req 2 writes 0xDEADBEEF to addr 0x00005 -> mem_en=1, mem_we=1, mem_addr=5, mem_wdata=0xDEADBEEF in the beat cycle, and no rsp_valid.
REQ-035 Bench SHALL check: owner 0 drops valid after 2 beats while req 1 is valid -> IDLE next cycle, then grant_id=1; rr_ptr=1.
REQ-036 Bench SHALL check: arst_n_in asserted the cycle after a read beat -> rsp_valid stays 0 and all outputs are at reset values while reset is asserted.
REQ-037 Bench SHALL check: a random 10k-cycle run against a reference memory model -> every read returns the last written value, and no requester waits more than 2 grants.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the external-memory port arbiter: requester ids,
// FSM state encoding and default burst length.
// Latency/backpressure: n/a (types and constants only).
package mem_arb_pkg;

    // Requester ids; the index of each requester in the req_* vectors.
    localparam int REQ_FEAT = 0;   // feature fetch
    localparam int REQ_WGT  = 1;   // weight fetch
    localparam int REQ_OUT  = 2;   // output writeback

    localparam int NB_REQ_DFLT    = REQ_OUT + 1;
    localparam int MAX_BURST_DFLT = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping cyclically.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found=0 when no request bit is set.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index for this pick
//   idx   : selected requester (0 when found=0)
//   found : at least one request bit set
module rr_pick #(
    parameter  int NB_REQ = 3,
    localparam int ID_W   = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [ID_W-1:0]   idx,
    output logic              found
);

    // rot[k] is the request of requester (ptr + k) mod NB_REQ.
    logic [NB_REQ-1:0] rot;
    // ptr + offset before wrapping back into 0..NB_REQ-1; needs one extra bit.
    logic [ID_W:0]     sum;

    always_comb begin
        rot   = NB_REQ'({req, req} >> ptr);
        found = 1'b0;
        sum   = '0;
        // Scan from the far end so the nearest set bit is the one that sticks.
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (ID_W + 1)'(k);
            end
        end
        if (sum >= (ID_W + 1)'(NB_REQ)) begin
            sum = sum - (ID_W + 1)'(NB_REQ);
        end
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port among NB_REQ requesters.
// Latency: 1 bubble cycle per grant, commands pass straight through; read data 1 cycle after the beat.
// Backpressure: req_ready only for the owner while granted; owner drops valid or hits MAX_BURST to release.
//   clk, arst_n_in          : clock and async active-low reset
//   req_valid/ready/we/addr/wdata : per-requester command channel
//   rsp_valid (one-hot), rsp_data : read response, data shared by all requesters
//   mem_en/we/addr/wdata/rdata    : external memory port (1-cycle read latency)
//   grant_id, busy                : current owner and GRANT-state flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NB_REQ         = NB_REQ_DFLT,
    parameter  int EXT_MEM_HEIGHT = 1 << 20,
    parameter  int EXT_MEM_WIDTH  = 32,
    parameter  int MAX_BURST      = MAX_BURST_DFLT,
    localparam int ADDR_W         = $clog2(EXT_MEM_HEIGHT),
    localparam int ID_W           = $clog2(NB_REQ)
) (
    input  logic                                   clk,
    input  logic                                   arst_n_in,
    input  logic [NB_REQ-1:0]                      req_valid,
    output logic [NB_REQ-1:0]                      req_ready,
    input  logic [NB_REQ-1:0]                      req_we,
    input  logic [NB_REQ-1:0][ADDR_W-1:0]          req_addr,
    input  logic [NB_REQ-1:0][EXT_MEM_WIDTH-1:0]   req_wdata,
    output logic [NB_REQ-1:0]                      rsp_valid,
    output logic [EXT_MEM_WIDTH-1:0]               rsp_data,
    output logic                                   mem_en,
    output logic                                   mem_we,
    output logic [ADDR_W-1:0]                      mem_addr,
    output logic [EXT_MEM_WIDTH-1:0]               mem_wdata,
    input  logic [EXT_MEM_WIDTH-1:0]               mem_rdata,
    output logic [ID_W-1:0]                        grant_id,
    output logic                                   busy
);

    localparam int              CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NB_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [NB_REQ-1:0] rsp_vld_q, rsp_vld_d;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic              beat;

    rr_pick #(
        .NB_REQ (NB_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The owner is always ready while granted, so a beat is just owner valid.
    assign beat = (state_q == ST_GRANT) && req_valid[owner_q];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Release when the owner goes quiet or this beat fills the burst;
                // the pointer moves past the owner so it ranks last next time.
                if (!req_valid[owner_q] || (beat_cnt_q == LAST_CNT)) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_GRANT) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    // Command fields are zeroed outside a beat so the port is quiet in IDLE and reset.
    always_comb begin
        mem_en    = beat;
        mem_we    = beat & req_we[owner_q];
        mem_addr  = beat ? req_addr[owner_q]  : '0;
        mem_wdata = beat ? req_wdata[owner_q] : '0;
    end

    // Remember who issued a read so the data coming back next cycle is tagged.
    always_comb begin
        rsp_vld_d = '0;
        if (beat && !req_we[owner_q]) begin
            rsp_vld_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            rsp_vld_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rsp_vld_q  <= rsp_vld_d;
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = (|rsp_vld_q) ? mem_rdata : '0;
    assign grant_id  = owner_q;
    assign busy      = (state_q == ST_GRANT);

endmodule
